// File: rtl/remote_comm.sv
// Host-side BLE endpoint: sends 16-bit commands as two 8N1 frames (high byte first)
// and decodes 8-bit status bytes from the robot. The TX and RX paths are independent.
module remote_comm #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        tx_busy,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_t;

  tx_state_t   tx_state, tx_state_nxt;
  logic [15:0] hold, hold_nxt;
  logic [9:0]  tx_shift, tx_shift_nxt;
  logic [15:0] tx_baud, tx_baud_nxt;
  logic [3:0]  tx_bit, tx_bit_nxt;
  logic        tx_nxt, cmd_snt_nxt, accept;

  rx_state_t   rx_state, rx_state_nxt;
  logic [1:0]  rx_sync;
  logic        rx_prev, rx_s;
  logic [15:0] rx_cnt, rx_cnt_nxt;
  logic [3:0]  rx_bit, rx_bit_nxt;
  logic [7:0]  rx_shift, rx_shift_nxt;
  logic [7:0]  resp_nxt;
  logic        rx_set, rx_clr;

  assign tx_busy = (tx_state != TX_IDLE) | cmd_snt;
  assign rx_s    = rx_sync[1];

  // The holding register is stored byte-rotated so the byte for the next frame
  // always sits in hold[15:8]; the first frame comes straight from cmd.
  always_comb begin
    tx_state_nxt = tx_state;
    hold_nxt     = hold;
    tx_shift_nxt = tx_shift;
    tx_baud_nxt  = tx_baud;
    tx_bit_nxt   = tx_bit;
    tx_nxt       = TX;
    cmd_snt_nxt  = 1'b0;
    accept       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (snd_cmd && !cmd_snt) begin
          accept       = 1'b1;
          hold_nxt     = {cmd[7:0], cmd[15:8]};
          tx_shift_nxt = {1'b1, cmd[15:8], 1'b0};
          tx_nxt       = 1'b0;
          tx_baud_nxt  = '0;
          tx_bit_nxt   = '0;
          tx_state_nxt = TX_HIGH;
        end
      end
      TX_HIGH, TX_LOW: begin
        if (tx_baud != BAUD_LAST) begin
          tx_baud_nxt = tx_baud + 16'd1;
        end else begin
          tx_baud_nxt = '0;
          if (tx_bit != 4'd9) begin
            tx_bit_nxt   = tx_bit + 4'd1;
            tx_shift_nxt = {1'b1, tx_shift[9:1]};
            tx_nxt       = tx_shift[1];
          end else if (tx_state == TX_HIGH) begin
            tx_bit_nxt   = '0;
            tx_shift_nxt = {1'b1, hold[15:8], 1'b0};
            hold_nxt     = {hold[7:0], hold[15:8]};
            tx_nxt       = 1'b0;
            tx_state_nxt = TX_LOW;
          end else begin
            tx_nxt       = 1'b1;
            cmd_snt_nxt  = 1'b1;
            tx_state_nxt = TX_IDLE;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      hold     <= '0;
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      TX       <= 1'b1;
      cmd_snt  <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      hold     <= hold_nxt;
      tx_shift <= tx_shift_nxt;
      tx_baud  <= tx_baud_nxt;
      tx_bit   <= tx_bit_nxt;
      TX       <= tx_nxt;
      cmd_snt  <= cmd_snt_nxt;
    end
  end

  // Counter starts at half a bit so every later sample lands mid-bit.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    resp_nxt     = resp;
    rx_set       = 1'b0;
    rx_clr       = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_cnt_nxt   = BAUD_HALF;
          rx_clr       = 1'b1;
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt != BAUD_LAST) begin
          rx_cnt_nxt = rx_cnt + 16'd1;
        end else begin
          rx_cnt_nxt   = '0;
          rx_bit_nxt   = '0;
          rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt != BAUD_LAST) begin
          rx_cnt_nxt = rx_cnt + 16'd1;
        end else begin
          rx_cnt_nxt = '0;
          if (rx_bit != 4'd8) begin
            rx_shift_nxt = {rx_s, rx_shift[7:1]};
            rx_bit_nxt   = rx_bit + 4'd1;
          end else begin
            resp_nxt     = rx_shift;
            rx_set       = 1'b1;
            rx_state_nxt = RX_IDLE;
          end
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      resp     <= '0;
      resp_rdy <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], RX};
      rx_prev  <= rx_s;
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
      resp     <= resp_nxt;
      resp_rdy <= rx_set | (resp_rdy & ~(rx_clr | accept));
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: per-cycle comparison against a timeline model of the
// serial link, plus directed vectors with hand-computed expectations.
module tb_remote_comm;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = '0;
  logic        snd_cmd = 1'b0;
  logic        cmd_snt, tx_busy, TX, RX;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        rx_drv = 1'b1;
  logic        loop = 1'b0;

  int tests = 0;
  int fails = 0;

  assign RX = loop ? TX : rx_drv;
  always #10 clk = ~clk;

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
    .tx_busy(tx_busy), .TX(TX), .RX(RX), .resp(resp), .resp_rdy(resp_rdy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle-time %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit near(input int a, input int b);
    return (a - b <= 2) && (b - a <= 2);
  endfunction

  // Line level of bit idx (0..19) of the two-frame transmission of w.
  function automatic logic frame_bit(input logic [15:0] w, input int idx);
    int j;
    logic [7:0] b;
    j = idx % 10;
    b = (idx < 10) ? w[15:8] : w[7:0];
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // ---------------- model ----------------
  typedef struct {
    int         fall;
    logic [7:0] data;
    logic       glitch;
  } rx_evt_t;

  rx_evt_t     rxq[$];
  int          cyc = 0;
  int          acc = -100000;
  logic        m_active = 1'b0;
  logic [15:0] m_word = '0;
  logic        m_rdy = 1'b0;
  logic [7:0]  m_resp = '0;
  int          last_evt = -100000;

  always @(posedge clk) begin
    logic busy_now;
    busy_now = m_active && (cyc - acc <= 20 * B);
    cyc = cyc + 1;
    if (!rst_n) begin
      m_active = 1'b0;
      m_rdy    = 1'b0;
      m_resp   = '0;
      rxq.delete();
    end else begin
      if (snd_cmd && !busy_now) begin
        acc      = cyc;
        m_active = 1'b1;
        m_word   = cmd;
        m_rdy    = 1'b0;
        if (loop) begin
          rxq.push_back('{fall: cyc, data: cmd[15:8], glitch: 1'b0});
          rxq.push_back('{fall: cyc + 10 * B, data: cmd[7:0], glitch: 1'b0});
        end
      end
      if (rxq.size() > 0) begin
        if (cyc == rxq[0].fall + 2) begin
          m_rdy = 1'b0;
          if (rxq[0].glitch) begin
            last_evt = cyc;
            void'(rxq.pop_front());
          end
        end else if (cyc == rxq[0].fall + 2 + 19 * B / 2) begin
          m_rdy    = 1'b1;
          m_resp   = rxq[0].data;
          last_evt = cyc;
          void'(rxq.pop_front());
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int   k;
    logic e_tx, e_busy, e_snt;
    bit   dc;
    if (!rst_n) begin
      check("rst_tx", TX, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_snt", cmd_snt, 0);
      check("rst_rdy", resp_rdy, 0);
      check("rst_resp", resp, 0);
    end else begin
      k = cyc - acc;
      e_tx = 1'b1; e_busy = 1'b0; e_snt = 1'b0;
      if (m_active && k <= 20 * B) begin
        e_busy = 1'b1;
        if (k < 20 * B) e_tx = frame_bit(m_word, k / B);
        else e_snt = 1'b1;
      end
      check("tx_line", TX, e_tx);
      check("tx_busy", tx_busy, e_busy);
      check("cmd_snt", cmd_snt, e_snt);
      dc = near(cyc, last_evt) ||
           (rxq.size() > 0 && (near(cyc, rxq[0].fall + 2) ||
                               near(cyc, rxq[0].fall + 2 + 19 * B / 2)));
      if (!dc) begin
        check("resp_rdy", resp_rdy, m_rdy);
        check("resp", resp, m_resp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xfer(input logic [15:0] c, input int inject_at, input logic [15:0] c2,
                      output logic [19:0] bits, output int snt_e, output int snt_n,
                      output logic [7:0] mid_resp, output int rise_e);
    logic prev_rdy;
    bits = '1; snt_e = -1; snt_n = 0; mid_resp = '0; rise_e = -1; prev_rdy = 1'b1;
    @(posedge clk); #1 cmd = c; snd_cmd = 1'b1;
    @(posedge clk); #1 snd_cmd = 1'b0;
    for (int e = 1; e <= 400; e++) begin
      @(negedge clk);
      if ((e - 1) / B < 20 && (e - 1) % B == B / 2) bits[(e - 1) / B] = TX;
      if (cmd_snt) begin
        snt_n++;
        if (snt_e < 0) snt_e = e;
      end
      if (e == 170) begin
        mid_resp = resp;
        prev_rdy = resp_rdy;
      end else if (e > 170) begin
        if (resp_rdy && !prev_rdy && rise_e < 0) rise_e = e;
        prev_rdy = resp_rdy;
      end
      @(posedge clk); #1;
      if (inject_at != 0 && e == inject_at) begin
        cmd = c2;
        snd_cmd = 1'b1;
      end else begin
        snd_cmd = 1'b0;
      end
    end
  endtask

  task automatic send_rx(input logic [7:0] d, output logic rdy_mid);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    rdy_mid = 1'bx;
    @(posedge clk); #1;
    rxq.push_back('{fall: cyc, data: d, glitch: 1'b0});
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      for (int c = 0; c < B; c++) begin
        if (i == 1 && c == 2) rdy_mid = resp_rdy;
        @(posedge clk); #1;
      end
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] bits;
    int          snt_e, snt_n, rise_e;
    logic [7:0]  mid_resp;
    logic        rdy_mid;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_tx", TX, 1);
    check("idle_busy", tx_busy, 0);
    check("idle_rdy", resp_rdy, 0);
    check("idle_resp", resp, 8'h00);

    // Serialization of 0x4A37
    xfer(16'h4A37, 0, 16'h0000, bits, snt_e, snt_n, mid_resp, rise_e);
    check("ser_start_hi", bits[0], 0);
    check("ser_byte_hi", bits[8:1], 8'h4A);
    check("ser_stop_hi", bits[9], 1);
    check("ser_start_lo", bits[10], 0);
    check("ser_byte_lo", bits[18:11], 8'h37);
    check("ser_stop_lo", bits[19], 1);
    check("ser_snt_edge", snt_e, 321);
    check("ser_snt_count", snt_n, 1);

    // Busy rejection
    xfer(16'h1234, 50, 16'hFFFF, bits, snt_e, snt_n, mid_resp, rise_e);
    check("busy_byte_hi", bits[8:1], 8'h12);
    check("busy_byte_lo", bits[18:11], 8'h34);
    check("busy_snt_count", snt_n, 1);
    check("busy_snt_edge", snt_e, 321);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("busy_after_idle", tx_busy, 0);

    // Glitch rejection, then a clean byte
    @(posedge clk); #1 rx_drv = 1'b0;
    rxq.push_back('{fall: cyc, data: 8'h00, glitch: 1'b1});
    repeat (4) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("glitch_no_rdy", resp_rdy, 0);
    send_rx(8'h3C, rdy_mid);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("after_glitch_resp", resp, 8'h3C);
    check("after_glitch_rdy", resp_rdy, 1);

    // Response decode
    send_rx(8'hA5, rdy_mid);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("dec_a5_resp", resp, 8'hA5);
    check("dec_a5_rdy", resp_rdy, 1);
    send_rx(8'h5A, rdy_mid);
    check("dec_clear_at_start", rdy_mid, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("dec_5a_resp", resp, 8'h5A);
    check("dec_5a_rdy", resp_rdy, 1);

    // Loopback / full duplex
    repeat (5) @(posedge clk);
    #1 loop = 1'b1;
    xfer(16'hC3A5, 0, 16'h0000, bits, snt_e, snt_n, mid_resp, rise_e);
    check("loop_resp_first", mid_resp, 8'hC3);
    check("loop_resp_second", resp, 8'hA5);
    check("loop_rdy_rose", rise_e > 0, 1);
    check("loop_rdy_vs_snt", (rise_e - snt_e <= 10) && (snt_e - rise_e <= 10), 1);
    repeat (5) @(posedge clk);
    #1 loop = 1'b0;

    // Reset mid-frame with a received byte pending
    @(posedge clk); #1 cmd = 16'h0F0F; snd_cmd = 1'b1;
    @(posedge clk); #1 snd_cmd = 1'b0;
    repeat (10) @(posedge clk);
    send_rx(8'h81, rdy_mid);
    @(negedge clk);
    check("pre_rst_busy", tx_busy, 1);
    check("pre_rst_rdy", resp_rdy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_now_tx", TX, 1);
    check("rst_now_busy", tx_busy, 0);
    check("rst_now_rdy", resp_rdy, 0);
    check("rst_now_resp", resp, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("post_rst_tx", TX, 1);
    check("post_rst_busy", tx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/remote_comm.md
# remote_comm

Host-side BLE endpoint for the Knight's Tour robot, and the opposite end of the robot's command link. The robot receives 16-bit commands and answers with an 8-bit status byte. This block serializes each 16-bit command onto `TX` as two 8N1 UART frames, high byte first. It independently deserializes status bytes arriving on `RX` (0xA5 done, 0x5A in progress). It serves as the stand-in for the phone/BLE module in full-chip benches, and as the host interface on the FPGA test fixture.

## Interface
- `BAUD_DIV`, 5208, clocks per UART bit (50 MHz / 9600 baud); legal range 16..65535.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd`  in  16  command to send; sampled only on an accepted `snd_cmd`.
- `snd_cmd`  in  1  single-cycle request to transmit `cmd`.
- `cmd_snt`  out  1  one-cycle pulse when the low byte's stop bit completes.
- `tx_busy`  out  1  high from acceptance of `snd_cmd` until the `cmd_snt` cycle, inclusive.
- `TX`  out  1  serial output to robot `RX`; idles high.
- `RX`  in  1  serial input from robot `TX`; asynchronous to `clk`.
- `resp`  out  8  last received status byte.
- `resp_rdy`  out  1  high while `resp` holds a new, unconsumed byte.

## Operation
- Transmit FSM has three states: IDLE, HIGH, LOW.
  - IDLE: when `snd_cmd` is high, latch `cmd` into a 16-bit holding register, then go to HIGH.
  - HIGH: shift out frame `{stop=1, cmd[15:8], start=0}`, LSB first. After 10 bit-times, go to LOW.
  - LOW: send `cmd[7:0]` the same way. After 10 bit-times, pulse `cmd_snt` and return to IDLE.
  - There is no idle gap between the two frames.
- Transmit datapath:
  - 10-bit shift register, loaded per frame.
  - 16-bit baud counter, counting 0..BAUD_DIV-1.
  - 4-bit bit counter, counting 0..9.
  - `TX` is driven from a flop, not from combinational logic.
- `snd_cmd` while `tx_busy` is ignored. No queueing; the holding register is not overwritten.
- Receive FSM has three states: IDLE, START, DATA.
  - `RX` passes through a two-flop synchronizer, preset to 1 on reset.
  - IDLE: a synchronized falling edge loads the baud counter with BAUD_DIV/2 and goes to START.
  - START: at mid-bit, if the synchronized RX is high, treat it as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: take 9 samples, each BAUD_DIV clocks apart: 8 data bits LSB first, then the stop bit.
  - After the stop sample, load `resp` and set `resp_rdy`.
  - The stop-bit value is not checked. Framing errors are not reported.
- `resp_rdy` clearing:
  - Cleared by an accepted `snd_cmd`, or by the next start-bit detection.
  - If a set and a clear occur in the same cycle, the set wins.
- Receive and transmit paths are fully independent. Full-duplex operation is legal.

## Timing
- Reset values: `TX`=1, `cmd_snt`=0, `tx_busy`=0, `resp`=0x00, `resp_rdy`=0. Both FSMs reset to IDLE.
- Reset mid-frame: `TX` returns to 1 asynchronously. A partial frame is abandoned and not resumed.
- Transmit latency, with `snd_cmd` sampled high at edge 0:
  - `tx_busy` and `TX`=0 (start bit) from edge 1.
  - Each bit lasts exactly BAUD_DIV clocks.
  - Low-byte start bit begins at edge 1+10·BAUD_DIV.
  - `cmd_snt` is high for one cycle starting at edge 1+20·BAUD_DIV. `tx_busy` falls the following edge.
  - A new `snd_cmd` is accepted in the cycle after `cmd_snt`.
- Receive latency:
  - `resp_rdy` rises 2 clocks (synchronizer) plus roughly 9.5·BAUD_DIV clocks after the `RX` falling edge.
  - This is within ±2 clocks of the stop-bit midpoint.
- Bit-rate tolerance: the receiver must decode a transmitter whose bit period differs by up to ±3%.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 mid-frame.
  - Required: `TX`=1, `tx_busy`=0, `resp_rdy`=0 immediately. After release, `TX` stays 1 with no stray bits.
- Command serialization:
  - Stimulus: BAUD_DIV=16, `cmd`=0x4A37, pulse `snd_cmd`.
  - Required: `TX` carries 0,0x4A LSB-first,1,0,0x37 LSB-first,1, each bit 16 clocks. `cmd_snt` fires exactly at edge 321.
- Busy rejection:
  - Stimulus: pulse `snd_cmd` with 0x1234, then `snd_cmd` with 0xFFFF 50 clocks later.
  - Required: only 0x1234 appears on `TX`, and exactly one `cmd_snt` pulse.
- Response decode:
  - Stimulus: drive `RX` with 0xA5 at BAUD_DIV=16, then 0x5A.
  - Required: `resp`=0xA5 with `resp_rdy` high, then `resp_rdy` clears at the second start bit, then `resp`=0x5A.
- Glitch rejection:
  - Stimulus: drive `RX` low for 4 clocks at BAUD_DIV=16.
  - Required: no `resp_rdy`, and the receiver is back in IDLE. A following clean 0x3C decodes correctly.
- Loopback / full duplex:
  - Stimulus: connect `TX` to `RX` and send 0xC3A5.
  - Required: `resp` reads 0xC3 after the first frame, then 0xA5 after the second. `cmd_snt` and the second `resp_rdy` rise within 10 clocks of each other.
